// File: rtl/conv_pkg.sv
// conv_pkg: shared state encoding, size derivations and saturation helper for the conv MAC engine.
package conv_pkg;
    typedef enum logic [1:0] {IDLE, ACCUM, FINAL, OUTPUT} state_t;
    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
    function automatic int taps_of(input int k);
        return k * k;
    endfunction
    function automatic int groups_of(input int taps, input int lanes);
        return (taps + lanes - 1) / lanes;
    endfunction
    function automatic int acc_w_of(input int pix_w, input int ker_w, input int taps);
        return pix_w + ker_w + 1 + clog2(taps);
    endfunction
    // Widths of 63+ cannot be exceeded by any accumulator this engine builds.
    function automatic logic signed [63:0] sat_val(input logic signed [63:0] v, input int w, input logic sgn);
        logic signed [63:0] hi, lo;
        if (w >= 63) return v;
        hi = sgn ? (64'sd1 <<< (w - 1)) - 64'sd1 : (64'sd1 <<< w) - 64'sd1;
        lo = sgn ? -hi - 64'sd1 : 64'sd0;
        return v > hi ? hi : v < lo ? lo : v;
    endfunction
endpackage

// File: rtl/conv_mac_engine_if.sv
// conv_mac_engine_if: beat input and result output handshakes of the conv MAC engine.
interface conv_mac_engine_if #(
    parameter int DATA_W = 108,
    parameter int OUT_W  = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic              out_sat;
    modport master(output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_sat);
    modport slave(input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_sat);
endinterface

// File: rtl/conv_mac_lane.sv
// conv_mac_lane: one kernel-tap multiply, sign-aware, forced to zero for padded taps.
module conv_mac_lane #(
    parameter int PIX_W      = 8,
    parameter int KER_W      = 4,
    parameter int KER_SIGNED = 0,
    parameter int W          = 13
) (
    input  logic                en,
    input  logic [KER_W-1:0]    ker,
    input  logic [PIX_W-1:0]    pix,
    output logic signed [W-1:0] prod
);
    logic signed [W-1:0] k_e, p_e;
    assign k_e  = KER_SIGNED != 0 ? W'($signed(ker)) : W'(ker);
    assign p_e  = W'(pix);
    assign prod = en ? k_e * p_e : '0;
endmodule

// File: rtl/conv_mac_engine.sv
// conv_mac_engine: KxK convolution MAC folded over LANES multipliers, shifted and saturated onto a valid/ready output.
// Build option CONV_RELU_EN: in signed mode negative results are output as zero.
module conv_mac_engine
    import conv_pkg::*;
#(
    parameter int K          = 3,
    parameter int PIX_W      = 8,
    parameter int KER_W      = 4,
    parameter int KER_SIGNED = 0,
    parameter int LANES      = 3,
    parameter int SHIFT      = 0,
    parameter int OUT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    conv_mac_engine_if.slave bus,
    output logic             busy
);
    localparam int TAPS  = taps_of(K);
    localparam int N     = groups_of(TAPS, LANES);
    localparam int ACC_W = acc_w_of(PIX_W, KER_W, TAPS);
    localparam int LW    = PIX_W + KER_W + KER_SIGNED + 1;
    localparam int GW    = N > 1 ? clog2(N) : 1;
    localparam int TW    = TAPS > 1 ? clog2(TAPS) : 1;

    state_t                  state;
    logic [GW-1:0]           grp;
    logic signed [ACC_W-1:0] acc, grp_sum;
    logic [KER_W-1:0]        ker_q [TAPS];
    logic [PIX_W-1:0]        pix_q [TAPS];
    logic                    lane_en [LANES];
    logic [TW-1:0]           lane_idx [LANES];
    logic signed [LW-1:0]    prod [LANES];
    logic signed [63:0]      shifted, clamped;
    logic                    relu, in_fire;

    assign in_fire = state == IDLE && bus.in_valid && bus.in_ready;
    assign busy    = state != IDLE;

    always_ff @(posedge clk)
        if (in_fire)
            for (int i = 0; i < TAPS; i++) begin
                ker_q[i] <= bus.in_data[TAPS*PIX_W + (TAPS-1-i)*KER_W +: KER_W];
                pix_q[i] <= bus.in_data[(TAPS-1-i)*PIX_W +: PIX_W];
            end

    // Lanes past the last tap read tap 0 but are disabled, so they add nothing.
    always_comb
        for (int i = 0; i < LANES; i++) begin
            lane_en[i]  = int'(grp) * LANES + i < TAPS;
            lane_idx[i] = lane_en[i] ? TW'(int'(grp) * LANES + i) : '0;
        end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        conv_mac_lane #(.PIX_W(PIX_W), .KER_W(KER_W), .KER_SIGNED(KER_SIGNED), .W(LW)) u_lane (
            .en  (lane_en[l]),
            .ker (ker_q[lane_idx[l]]),
            .pix (pix_q[lane_idx[l]]),
            .prod(prod[l])
        );
    end

    always_comb begin
        grp_sum = '0;
        for (int i = 0; i < LANES; i++) grp_sum += ACC_W'(prod[i]);
    end

    assign shifted = 64'(acc) >>> SHIFT;
    assign clamped = sat_val(shifted, OUT_W, KER_SIGNED != 0);
`ifdef CONV_RELU_EN
    assign relu = KER_SIGNED != 0 && shifted < 0;
`else
    assign relu = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state         <= IDLE;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_sat   <= 1'b0;
            acc           <= '0;
            grp           <= '0;
        end else begin
            case (state)
                IDLE:
                    if (in_fire) begin
                        acc          <= '0;
                        grp          <= '0;
                        bus.in_ready <= 1'b0;
                        state        <= ACCUM;
                    end else
                        bus.in_ready <= 1'b1;
                ACCUM: begin
                    acc <= acc + grp_sum;
                    if (grp == GW'(N - 1)) state <= FINAL;
                    else grp <= grp + 1'b1;
                end
                FINAL: begin
                    bus.out_data  <= relu ? '0 : clamped[OUT_W-1:0];
                    bus.out_sat   <= !relu && clamped != shifted;
                    bus.out_valid <= 1'b1;
                    state         <= OUTPUT;
                end
                default:
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
            endcase
        end
endmodule

// File: tb/tb_conv_mac_engine.sv
// tb_conv_mac_engine: directed beats through six engine builds sharing one stimulus stream.
module tb_conv_mac_engine;
    import conv_pkg::*;
`ifdef CONV_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif
    // Columns: default, LANES=1, LANES=4, OUT_W=8, OUT_W=8+SHIFT=4, KER_SIGNED=1.
    localparam int ED [5][6] = '{
        '{90,    90,    90,    90,  5,   90},
        '{34425, 34425, 34425, 255, 255, RELU ? 0 : -2295},
        '{2295,  2295,  2295,  255, 143, 2295},
        '{2700,  2700,  2700,  255, 168, RELU ? 0 : -180},
        '{2445,  2445,  2445,  255, 152, 13}
    };
    localparam logic [5:0] ES [5] = '{6'b000000, 6'b011000, 6'b001000, 6'b001000, 6'b001000};
    localparam logic [3:0] KV [5] = '{4'd1, 4'd15, 4'd1, 4'd15, 4'd0};
    localparam logic [7:0] PV [5] = '{8'd10, 8'd255, 8'd255, 8'd20, 8'd0};

    logic clk = 1'b0, rst_n = 1'b0, vld = 1'b0, rdy = 1'b0;
    logic [107:0] din = '0;
    logic [5:0] vb, sb, rb, bb;
    logic [31:0] od [6];
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    conv_mac_engine_if #(.DATA_W(108), .OUT_W(32)) i0 ();
    conv_mac_engine_if #(.DATA_W(108), .OUT_W(32)) i1 ();
    conv_mac_engine_if #(.DATA_W(108), .OUT_W(32)) i2 ();
    conv_mac_engine_if #(.DATA_W(108), .OUT_W(8))  i3 ();
    conv_mac_engine_if #(.DATA_W(108), .OUT_W(8))  i4 ();
    conv_mac_engine_if #(.DATA_W(108), .OUT_W(32)) i5 ();

    conv_mac_engine d0 (.clk(clk), .rst_n(rst_n), .bus(i0), .busy(bb[0]));
    conv_mac_engine #(.LANES(1)) d1 (.clk(clk), .rst_n(rst_n), .bus(i1), .busy(bb[1]));
    conv_mac_engine #(.LANES(4)) d2 (.clk(clk), .rst_n(rst_n), .bus(i2), .busy(bb[2]));
    conv_mac_engine #(.OUT_W(8)) d3 (.clk(clk), .rst_n(rst_n), .bus(i3), .busy(bb[3]));
    conv_mac_engine #(.OUT_W(8), .SHIFT(4)) d4 (.clk(clk), .rst_n(rst_n), .bus(i4), .busy(bb[4]));
    conv_mac_engine #(.KER_SIGNED(1)) d5 (.clk(clk), .rst_n(rst_n), .bus(i5), .busy(bb[5]));

    assign {i5.in_valid, i4.in_valid, i3.in_valid, i2.in_valid, i1.in_valid, i0.in_valid} = {6{vld}};
    assign {i5.out_ready, i4.out_ready, i3.out_ready, i2.out_ready, i1.out_ready, i0.out_ready} = {6{rdy}};
    assign i0.in_data = din;
    assign i1.in_data = din;
    assign i2.in_data = din;
    assign i3.in_data = din;
    assign i4.in_data = din;
    assign i5.in_data = din;
    assign vb = {i5.out_valid, i4.out_valid, i3.out_valid, i2.out_valid, i1.out_valid, i0.out_valid};
    assign sb = {i5.out_sat, i4.out_sat, i3.out_sat, i2.out_sat, i1.out_sat, i0.out_sat};
    assign rb = {i5.in_ready, i4.in_ready, i3.in_ready, i2.in_ready, i1.in_ready, i0.in_ready};
    assign od[0] = i0.out_data;
    assign od[1] = i1.out_data;
    assign od[2] = i2.out_data;
    assign od[3] = {24'd0, i3.out_data};
    assign od[4] = {24'd0, i4.out_data};
    assign od[5] = i5.out_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Beat n < 4: every tap uses KV[n]/PV[n]; beat 4: tap i has k=i+1, p=10*i+1.
    function automatic logic [107:0] pack(input int n);
        logic [107:0] d = '0;
        for (int i = 0; i < 9; i++) begin
            d[72 + (8-i)*4 +: 4] = n == 4 ? 4'(i + 1) : KV[n];
            d[(8-i)*8 +: 8]      = n == 4 ? 8'(10*i + 1) : PV[n];
        end
        return d;
    endfunction

    task automatic send(input int n);
        @(negedge clk);
        din = pack(n);
        vld = 1'b1;
        @(posedge clk);
        #1 vld = 1'b0;
        din = '0;
    endtask

    task automatic run_beat(input int n, input int hold);
        send(n);
        check($sformatf("b%0d.busy", n), 32'(bb), 32'h3f);
        check($sformatf("b%0d.in_ready_low", n), 32'(rb), 32'h0);
        repeat (3) @(posedge clk);
        #1 check($sformatf("b%0d.lat_early", n), 32'(vb[0]), 32'h0);
        @(posedge clk);
        #1 check($sformatf("b%0d.lat", n), 32'(vb[0]), 32'h1);
        for (int c = 0; c < 20 && vb != 6'h3f; c++) begin
            @(posedge clk);
            #1;
        end
        check($sformatf("b%0d.all_valid", n), 32'(vb), 32'h3f);
        for (int d = 0; d < 6; d++) begin
            check($sformatf("b%0d.d%0d.data", n, d), od[d], ED[n][d]);
            check($sformatf("b%0d.d%0d.sat", n, d), 32'(sb[d]), 32'(ES[n][d]));
        end
        for (int c = 0; c < hold; c++) begin
            @(posedge clk);
            #1 check($sformatf("b%0d.hold%0d.data", n, c), od[0], ED[n][0]);
            check($sformatf("b%0d.hold%0d.valid", n, c), 32'(vb[0]), 32'h1);
            check($sformatf("b%0d.hold%0d.in_ready", n, c), 32'(rb[0]), 32'h0);
            check($sformatf("b%0d.hold%0d.busy", n, c), 32'(bb[0]), 32'h1);
        end
        @(negedge clk);
        rdy = 1'b1;
        @(posedge clk);
        #1 rdy = 1'b0;
        check($sformatf("b%0d.ret_in_ready", n), 32'(rb), 32'h3f);
        check($sformatf("b%0d.ret_valid", n), 32'(vb), 32'h0);
        check($sformatf("b%0d.ret_busy", n), 32'(bb), 32'h0);
    endtask

    initial begin
        #12;
        check("rst.in_ready", 32'(rb), 32'h0);
        check("rst.out_valid", 32'(vb), 32'h0);
        check("rst.out_sat", 32'(sb), 32'h0);
        check("rst.out_data", od[0], 32'h0);
        check("rst.busy", 32'(bb), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("rel.in_ready", 32'(rb), 32'h3f);
        run_beat(0, 0);
        run_beat(1, 0);
        run_beat(2, 6);
        run_beat(3, 0);
        send(2);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check("arst.in_ready", 32'(rb), 32'h0);
        check("arst.out_valid", 32'(vb), 32'h0);
        check("arst.busy", 32'(bb), 32'h0);
        check("arst.out_data", od[0], 32'h0);
        check("arst.out_sat", 32'(sb), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("arst.rel_in_ready", 32'(rb), 32'h3f);
        run_beat(4, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
